seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 2..8.
REQ-002 Parameter SLOT_CYCLES, default 100000, clk cycles per digit slot; multiple of 16, minimum 16.
REQ-003 Parameter AN_ACTIVE_LOW, default 1, anode polarity; 1 = low enables digit.
REQ-004 Parameter SEG_ACTIVE_LOW, default 1, segment/dp polarity; 1 = low lights segment.
REQ-005 clk  in  1  single system clock; all logic rising-edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 digits  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i; digit 0 is least significant (rightmost).
REQ-008 dp_in  in  NUM_DIGITS  decimal point request per digit.
REQ-009 load  in  1  strobe; captures digits/dp_in into the pending buffer.
REQ-010 lz_blank  in  1  1 = suppress leading zeros.
REQ-011 bright  in  4  brightness level 0..15.
REQ-012 an  out  NUM_DIGITS  anode enables, registered.
REQ-013 seg  out  7  segments {g,f,e,d,c,b,a}, registered.
REQ-014 dp  out  1  decimal point, registered.
REQ-015 frame_done  out  1  one-cycle pulse at end of each full scan.

Function
REQ-016 Prescaler counts 0..SLOT_CYCLES-1 and wraps; at wrap, scan index advances by 1, with NUM_DIGITS-1 wrapping to 0.
REQ-017 Each slot is divided into 16 equal phases of SLOT_CYCLES/16 cycles; the selected anode is active only during phases 0..bright; all other anodes are always inactive.
REQ-018 bright=15 means the anode is on for the whole slot; bright=0 means the first 1/16 of the slot.
REQ-019 The anode is forced inactive during cycle 0 of each slot (anti-ghosting), regardless of bright.
REQ-020 On load=1, digits and dp_in are captured into a pending buffer; the display buffer takes the pending value at the next frame boundary (index wraps NUM_DIGITS-1 to 0).
REQ-021 If load coincides with the frame boundary, the newly loaded value is committed to the display buffer in that same cycle.
REQ-022 If several loads occur within one frame, the last one wins.
REQ-023 Hex decode: 0-9 and A,b,C,d,E,F use standard 7-segment glyphs; polarity is applied after decode.
REQ-024 Leading-zero blanking: with lz_blank=1, digit i>0 is blanked (all segments off, dp kept) when display nibbles N-1..i are all zero.
REQ-025 Digit 0 is never blanked.
REQ-026 lz_blank is sampled live each cycle.
REQ-027 an, seg and dp are registered and reflect the current index and buffer with 1-cycle latency.
REQ-028 frame_done asserts for exactly one cycle, in the cycle after the index wraps to 0.
REQ-029 bright changes take effect at the next phase evaluation; no glitch beyond a 1-cycle update.

Reset
REQ-030 While rst_n=0 at a clk edge:
 - prescaler, phase and index are cleared to 0
 - pending and display buffers are cleared to 0
 - an is driven all-inactive; seg and dp are driven unlit
 - frame_done is driven 0
REQ-031 Reset asserted mid-slot or mid-frame abandons the scan; after release, scanning restarts at digit 0, phase 0.
REQ-032 A load in the same cycle as reset is ignored.

Structure
REQ-033 Shared package seg7_pkg holds the glyph constants, the SEG_OFF/AN_OFF helpers and the nibble typedef.
REQ-034 One sub-module, seg7_hex_decode: combinational nibble to active-high 7-bit segment pattern.
REQ-035 Polarity inversion is done in the top level only.

Verification
REQ-036 NUM_DIGITS=4, SLOT_CYCLES=16, bright=15, load digits=16'h12AF -> an cycles 1110,1101,1011,0111, each 15 cycles active after 1 off cycle; seg shows F,A,2,1.
REQ-037 lz_blank=1, digits=16'h0050 -> digits 3 and 2 blank; digit 1 shows 5, digit 0 shows 0; with digits=16'h0000 only digit 0 is lit, showing 0.
REQ-038 bright=3, SLOT_CYCLES=32 -> anode active for cycles 1..7 of each slot, inactive for cycles 8..31.
REQ-039 Load 16'h1111 mid-frame, then 16'h2222 before the frame ends -> display keeps the old value until the boundary, then shows 2222; frame_done pulses once per 4*SLOT_CYCLES.
REQ-040 rst_n low for 1 cycle mid-slot -> next cycle an=1111, seg=7'h7F, frame_done=0; scanning restarts at digit 0 and the display buffer is 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph table, polarity helpers and nibble type for the 7-segment scanner
package seg7_pkg;

   typedef logic [3:0] nibble_t;

   // Active-high glyphs, bit order {g,f,e,d,c,b,a}; letters use the usual A b C d E F shapes
   localparam logic [6:0] GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [6:0] seg_off(input logic active_low);
      return active_low ? 7'h7F : 7'h00;
   endfunction

   function automatic logic [7:0] an_off(input logic active_low);
      return active_low ? 8'hFF : 8'h00;
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to active-high 7-segment pattern
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   nibble_t nib_t;

   assign nib_t = nib;
   assign seg   = GLYPH[nib_t];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scan controller with PWM brightness,
// leading-zero blanking and frame-synchronous display buffer
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int SLOT_CYCLES    = 100000,
   parameter int AN_ACTIVE_LOW  = 1,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    lz_blank,
   input  logic [3:0]              bright,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_done
);

   localparam int PH_CYCLES = SLOT_CYCLES / 16;
   localparam int PRE_W     = $clog2(SLOT_CYCLES);
   localparam int SUB_W     = (PH_CYCLES > 1) ? $clog2(PH_CYCLES) : 1;
   localparam int IDX_W     = $clog2(NUM_DIGITS);

   localparam logic [7:0]            AN_OFF8  = an_off(AN_ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] AN_OFF   = AN_OFF8[NUM_DIGITS-1:0];
   localparam logic [6:0]            SEG_OFF  = seg_off(SEG_ACTIVE_LOW != 0);
   localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(SLOT_CYCLES - 1);
   localparam logic [SUB_W-1:0]      SUB_LAST = SUB_W'(PH_CYCLES - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [PRE_W-1:0]        presc;
   logic [SUB_W-1:0]        sub_cnt;
   logic [3:0]              phase;
   logic [IDX_W-1:0]        idx;
   logic [4*NUM_DIGITS-1:0] pend_dig;
   logic [4*NUM_DIGITS-1:0] disp_dig;
   logic [NUM_DIGITS-1:0]   pend_dp;
   logic [NUM_DIGITS-1:0]   disp_dp;
   logic                    slot_end;
   logic                    frame_end;
   logic [NUM_DIGITS-1:0]   blank;
   logic                    zero_run;
   logic [NUM_DIGITS-1:0]   an_on;
   nibble_t                 cur_nib;
   logic [6:0]              glyph;

   assign slot_end  = (presc == PRE_LAST);
   assign frame_end = slot_end && (idx == IDX_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc   <= '0;
         sub_cnt <= '0;
         phase   <= '0;
         idx     <= '0;
      end else begin
         if (slot_end) begin
            presc   <= '0;
            sub_cnt <= '0;
            phase   <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            presc <= presc + 1'b1;
            if (sub_cnt == SUB_LAST) begin
               sub_cnt <= '0;
               phase   <= phase + 4'd1;
            end else begin
               sub_cnt <= sub_cnt + 1'b1;
            end
         end
      end
   end

   // A load landing on the frame boundary bypasses the pending buffer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_dig <= '0;
         pend_dp  <= '0;
         disp_dig <= '0;
         disp_dp  <= '0;
      end else begin
         if (load) begin
            pend_dig <= digits;
            pend_dp  <= dp_in;
         end
         if (frame_end) begin
            disp_dig <= load ? digits : pend_dig;
            disp_dp  <= load ? dp_in  : pend_dp;
         end
      end
   end

   always_comb begin
      zero_run = 1'b1;
      blank    = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zero_run = zero_run && (disp_dig[4*i +: 4] == 4'h0);
         blank[i] = zero_run;
      end
   end

   always_comb begin
      an_on = '0;
      if ((presc != '0) && (phase <= bright))
         an_on[idx] = 1'b1;
   end

   assign cur_nib = disp_dig[{idx, 2'b00} +: 4];

   seg7_hex_decode u_dec (
      .nib (cur_nib),
      .seg (glyph)
   );

   // XOR with the "off" pattern applies polarity in one place
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         an         <= AN_OFF;
         seg        <= SEG_OFF;
         dp         <= SEG_OFF[0];
         frame_done <= 1'b0;
      end else begin
         an         <= an_on ^ AN_OFF;
         seg        <= ((lz_blank && blank[idx]) ? 7'h00 : glyph) ^ SEG_OFF;
         dp         <= disp_dp[idx] ^ SEG_OFF[0];
         frame_done <= frame_end;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic        lz_blank = 1'b0;
   logic [15:0] digits = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  bright = 4'd15;
   logic [3:0]  an16, an32;
   logic [6:0]  seg16, seg32;
   logic        dp16, dp32, fd16, fd32;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(.NUM_DIGITS(4), .SLOT_CYCLES(16), .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut (
      .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in), .load(load),
      .lz_blank(lz_blank), .bright(bright), .an(an16), .seg(seg16), .dp(dp16), .frame_done(fd16)
   );

   seg7_scan_ctrl #(.NUM_DIGITS(4), .SLOT_CYCLES(32), .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut32 (
      .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in), .load(load),
      .lz_blank(lz_blank), .bright(bright), .an(an32), .seg(seg32), .dp(dp32), .frame_done(fd32)
   );

   logic [6:0] glyph [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Reference model: position derived from a cycle count since reset release
   int          slot_len [2] = '{16, 32};
   int          m_cnt [2];
   logic [15:0] m_pend [2];
   logic [15:0] m_disp [2];
   logic [3:0]  m_pdp [2];
   logic [3:0]  m_ddp [2];
   logic [3:0]  e_an [2];
   logic [6:0]  e_seg [2];
   logic        e_dp [2];
   logic        e_fd [2];
   int          last_pos;
   int          last_idx;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_step(input int m);
      int pos, idx, ph;
      if (!rst_n) begin
         m_cnt[m] = 0; m_pend[m] = '0; m_disp[m] = '0; m_pdp[m] = '0; m_ddp[m] = '0;
         e_an[m] = 4'hF; e_seg[m] = 7'h7F; e_dp[m] = 1'b1; e_fd[m] = 1'b0;
         if (m == 0) begin last_pos = -1; last_idx = -1; end
         return;
      end
      pos = m_cnt[m] % slot_len[m];
      idx = (m_cnt[m] / slot_len[m]) % N;
      ph  = pos / (slot_len[m] / 16);
      e_an[m] = (pos != 0 && ph <= int'(bright)) ? ~(4'b0001 << idx) : 4'hF;
      if (lz_blank && idx > 0 && (m_disp[m] >> (4 * idx)) == 16'h0)
         e_seg[m] = 7'h7F;
      else
         e_seg[m] = ~glyph[m_disp[m][4*idx +: 4]];
      e_dp[m] = ~m_ddp[m][idx];
      e_fd[m] = (pos == slot_len[m] - 1) && (idx == N - 1);
      if (e_fd[m]) begin
         m_disp[m] = load ? digits : m_pend[m];
         m_ddp[m]  = load ? dp_in  : m_pdp[m];
      end
      if (load) begin
         m_pend[m] = digits;
         m_pdp[m]  = dp_in;
      end
      if (m == 0) begin last_pos = pos; last_idx = idx; end
      m_cnt[m]++;
   endtask

   task automatic tick();
      model_step(0);
      model_step(1);
      @(negedge clk);
      chk("dut16_cycle", {an16, seg16, dp16, fd16}, {e_an[0], e_seg[0], e_dp[0], e_fd[0]});
      chk("dut32_cycle", {an32, seg32, dp32, fd32}, {e_an[1], e_seg[1], e_dp[1], e_fd[1]});
   endtask

   task automatic wait_fd16();
      int k;
      tick();
      for (k = 0; k < 200 && fd16 !== 1'b1; k++) tick();
      chk("frame_done_seen", {31'b0, fd16}, 32'd1);
   endtask

   typedef struct {
      logic [15:0] digits;
      logic [3:0]  dp;
      logic        lz;
      logic [27:0] seg;
   } vec_t;

   vec_t vec [6];
   int   bl  [3] = '{0, 3, 15};
   int   e16 [3] = '{0, 24, 120};
   int   e32 [3] = '{4, 28, 124};

   initial begin
      int cnt16, cnt32, k;

      vec[0] = '{16'h12AF, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}};
      vec[1] = '{16'h0050, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}};
      vec[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
      vec[3] = '{16'h0050, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h12, 7'h40}};
      vec[4] = '{16'h3B8C, 4'b0101, 1'b1, {7'h30, 7'h03, 7'h00, 7'h46}};
      vec[5] = '{16'h0D00, 4'b1000, 1'b1, {7'h7F, 7'h21, 7'h40, 7'h40}};

      rst_n = 1'b0;
      repeat (3) tick();
      chk("reset_state", {an16, seg16, dp16, fd16}, {4'hF, 7'h7F, 1'b1, 1'b0});
      rst_n = 1'b1;

      for (int v = 0; v < 6; v++) begin
         digits = vec[v].digits; dp_in = vec[v].dp; lz_blank = vec[v].lz; load = 1'b1;
         tick();
         load = 1'b0;
         wait_fd16();
         cnt16 = 0;
         for (int c = 0; c < 64; c++) begin
            tick();
            if (an16 == 4'b1110) cnt16++;
            if (last_pos == 8) begin
               chk("tbl_seg", {25'b0, seg16}, {25'b0, vec[v].seg[7*last_idx +: 7]});
               chk("tbl_an", {28'b0, an16}, {28'b0, ~(4'b0001 << last_idx)});
               chk("tbl_dp", {31'b0, dp16}, {31'b0, ~vec[v].dp[last_idx]});
            end
         end
         if (v == 0) chk("digit0_on_cycles", cnt16, 15);
      end

      for (int b = 0; b < 3; b++) begin
         bright = bl[b][3:0];
         tick();
         cnt16 = 0; cnt32 = 0;
         for (int c = 0; c < 128; c++) begin
            tick();
            if (an16 != 4'hF) cnt16++;
            if (an32 != 4'hF) cnt32++;
         end
         chk("bright_on_16", cnt16, e16[b]);
         chk("bright_on_32", cnt32, e32[b]);
      end
      bright = 4'd15;

      lz_blank = 1'b0;
      wait_fd16();
      repeat (20) tick();
      digits = 16'h1111; load = 1'b1; tick(); load = 1'b0;
      repeat (10) tick();
      digits = 16'h2222; load = 1'b1; tick(); load = 1'b0;
      wait_fd16();
      repeat (9) tick();
      chk("last_load_wins", {25'b0, seg16}, {25'b0, 7'h24});
      cnt16 = 0; cnt32 = 0;
      for (int c = 0; c < 256; c++) begin
         tick();
         if (fd16) cnt16++;
         if (fd32) cnt32++;
      end
      chk("fd_count_16", cnt16, 4);
      chk("fd_count_32", cnt32, 2);

      for (k = 0; k < 64 && (m_cnt[0] % 64) != 63; k++) tick();
      digits = 16'h4444; load = 1'b1; tick(); load = 1'b0;
      repeat (9) tick();
      chk("boundary_load", {25'b0, seg16}, {25'b0, 7'h19});

      for (k = 0; k < 16 && (m_cnt[0] % 16) != 7; k++) tick();
      rst_n = 1'b0; digits = 16'hFFFF; load = 1'b1;
      tick();
      chk("midslot_reset", {an16, seg16, fd16}, {4'hF, 7'h7F, 1'b0});
      rst_n = 1'b1; load = 1'b0;
      tick();
      chk("restart_digit0", {an16, seg16}, {4'hF, 7'h40});
      tick();
      chk("restart_an", {28'b0, an16}, {28'b0, 4'b1110});

      for (int c = 0; c < 3000; c++) begin
         load = ($urandom_range(0, 7) == 0);
         for (int d = 0; d < 4; d++)
            digits[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         dp_in = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) lz_blank = ~lz_blank;
         if ($urandom_range(0, 49) == 0) bright = 4'($urandom_range(0, 15));
         rst_n = ($urandom_range(0, 499) != 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
